rolling_key_decryption: RTL and testbench
=========================================

// Module: rolling_key_decryption
// PURPOSE
//  Parametrised successor to the single-shift Caesar decryptor. Decrypts a byte
//  stream with a rolling (Vigenere-style) key of up to KEY_CHARS shift characters.
//  Optionally wraps shifts inside a programmable alphabet window.
//  Sits in the decryption-module set, same stream interface: data/valid in, data/valid out, busy.
// PARAMETERS
//  D_WIDTH    8      data and key-character width
//  KEY_CHARS  4      max key characters; key bus = KEY_CHARS*D_WIDTH
//  WRAP_MODE  1      0: shift mod 2^D_WIDTH on all data; 1: wrap inside [ALPHA_LO,ALPHA_HI]
//  ALPHA_LO   8'h41  alphabet low bound ('A'); WRAP_MODE=1 only
//  ALPHA_HI   8'h5A  alphabet high bound ('Z'); ALPHA_LO<=ALPHA_HI; N=ALPHA_HI-ALPHA_LO+1
// PORTS
//  clk         in   1                 clock, all logic on rising edge
//  rst_n       in   1                 reset, asynchronous, active-low
//  data_i      in   D_WIDTH           ciphertext character
//  valid_i     in   1                 data_i valid this cycle
//  key         in   KEY_CHARS*D_WIDTH key chars; char i = key[i*D_WIDTH +: D_WIDTH]
//  key_len_i   in   $clog2(KEY_CHARS+1) number of key chars used, sampled with key_load_i
//  key_load_i  in   1                 1-cycle strobe: capture key/key_len_i, start LOAD
//  busy        out  1                 registered; 1 while LOAD in progress
//  data_o      out  D_WIDTH           plaintext; 0 whenever valid_o=0
//  valid_o     out  1                 data_o valid
// BEHAVIOUR
//  Reset (rst_n=0, async): busy=0, data_o=0, valid_o=0, state=IDLE, key regs=0, len=1, idx=0.
//  FSM: IDLE (no key) -> LOAD on key_load_i; LOAD -> RUN after len cycles;
//   RUN -> LOAD on key_load_i; key_load_i in LOAD restarts LOAD (counter=0, new capture).
//  Key capture: len = key_len_i clamped (0->1, >KEY_CHARS->KEY_CHARS).
//  LOAD: one char per cycle, i=0..len-1: shift[i] = WRAP_MODE ? char_i mod N : char_i.
//   busy=1 from the cycle after key_load_i for exactly len cycles; idx reset to 0.
//  While busy: valid_i ignored (dropped, no output); upstream must hold off.
//  Latency: 1 cycle. valid_i at edge t -> valid_o=1, data_o at t+1; else valid_o=0, data_o=0.
//  IDLE: data passes through unchanged (shift 0), idx not used.
//  RUN, WRAP_MODE=0: data_o = data_i - shift[idx] (mod 2^D_WIDTH); idx advances every char.
//  RUN, WRAP_MODE=1, ALPHA_LO<=data_i<=ALPHA_HI: off=data_i-ALPHA_LO;
//   data_o = ALPHA_LO + (off>=s ? off-s : off+N-s), s=shift[idx]; idx advances.
//  RUN, WRAP_MODE=1, data_i outside window: data_o=data_i, idx holds.
//  idx wrap: idx==len-1 advances to 0.
//  key_load_i with valid_i in RUN: char decrypted with old key/idx (output next cycle);
//   LOAD starts same edge; old key unused afterwards.
//  Reset mid-LOAD or mid-stream: immediate return to reset values, IDLE; key discarded.
//  No backpressure on output; valid_o is a 1-cycle pulse per accepted char.
// TESTING
//  1 reset, no key, valid_i 'D'(8'h44) -> next cycle valid_o=1, data_o=8'h44; idle data_o=0.
//  2 load shifts {1,2,3}, key_len_i=3 -> busy=1 exactly 3 cycles; then "DDDD" -> "CBAC".
//  3 load {3}, len 1; input 'A' -> 'X'(8'h58); 'C' -> 'Z'; window wrap correct.
//  4 load {1,2}; input 'B',' ','C' -> 'A',' ','A' (space passes, idx holds).
//  5 key_len_i=0, char0=8'h1D(29) -> len 1, shift 3; 'D' -> 'A'; also valid_i during busy
//    -> no valid_o; key_load_i + valid_i same cycle in RUN -> old-key output, then busy.
//  6 rst_n low mid-LOAD -> busy, valid_o, data_o 0 without clock; next 'D' passes as 'D'.

Source files
------------

// File: rtl/rolling_key_decryption.sv
// Rolling-key (Vigenere-style) stream decryptor with optional alphabet-window wrap.
// A key is loaded one character per cycle, then the shifts rotate across the data stream.
module rolling_key_decryption #(
    parameter int                 D_WIDTH   = 8,
    parameter int                 KEY_CHARS = 4,
    parameter int                 WRAP_MODE = 1,
    parameter logic [D_WIDTH-1:0] ALPHA_LO  = 8'h41,
    parameter logic [D_WIDTH-1:0] ALPHA_HI  = 8'h5A
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [D_WIDTH-1:0]              data_i,
    input  logic                            valid_i,
    input  logic [KEY_CHARS*D_WIDTH-1:0]    key,
    input  logic [$clog2(KEY_CHARS+1)-1:0]  key_len_i,
    input  logic                            key_load_i,
    output logic                            busy,
    output logic [D_WIDTH-1:0]              data_o,
    output logic                            valid_o
);

    localparam int LW = $clog2(KEY_CHARS + 1);
    localparam int IW = (KEY_CHARS > 1) ? $clog2(KEY_CHARS) : 1;
    localparam int NW = D_WIDTH + 1;
    localparam logic [NW-1:0] N_W = {1'b0, ALPHA_HI} - {1'b0, ALPHA_LO} + NW'(1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    state_t                       state;
    logic [KEY_CHARS*D_WIDTH-1:0] key_r;
    logic [D_WIDTH-1:0]           shift [KEY_CHARS];
    logic [LW-1:0]                len;
    logic [IW-1:0]                cnt;
    logic [IW-1:0]                idx;

    logic [LW-1:0]      len_clamp;
    logic [D_WIDTH-1:0] key_char;
    logic [D_WIDTH-1:0] shift_nxt;
    logic               load_last;
    logic               idx_last;
    logic [D_WIDTH-1:0] s;
    logic [D_WIDTH-1:0] off;
    logic               in_win;
    logic [D_WIDTH-1:0] dec;
    logic               adv;
    logic               accept;

    always_comb begin
        len_clamp = key_len_i;
        if (key_len_i == '0) begin
            len_clamp = LW'(1);
        end else if (key_len_i > LW'(KEY_CHARS)) begin
            len_clamp = LW'(KEY_CHARS);
        end
    end

    // Shifts are reduced into the window once at load time, keeping the data path a single compare.
    always_comb begin
        key_char  = key_r[cnt*D_WIDTH +: D_WIDTH];
        shift_nxt = key_char;
        if (WRAP_MODE != 0) begin
            shift_nxt = D_WIDTH'({1'b0, key_char} % N_W);
        end
        load_last = (LW'(cnt) == len - LW'(1));
        idx_last  = (LW'(idx) == len - LW'(1));
    end

    always_comb begin
        s      = shift[idx];
        off    = data_i - ALPHA_LO;
        in_win = (data_i >= ALPHA_LO) && (data_i <= ALPHA_HI);
        dec    = data_i;
        adv    = 1'b0;
        if (state == RUN) begin
            if (WRAP_MODE == 0) begin
                dec = data_i - s;
                adv = 1'b1;
            end else if (in_win) begin
                if (off >= s) begin
                    dec = ALPHA_LO + (off - s);
                end else begin
                    dec = ALPHA_LO + D_WIDTH'({1'b0, off} + N_W - {1'b0, s});
                end
                adv = 1'b1;
            end
        end
    end

    assign accept = valid_i && (state != LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            key_r   <= '0;
            len     <= LW'(1);
            cnt     <= '0;
            idx     <= '0;
            for (int i = 0; i < KEY_CHARS; i++) begin
                shift[i] <= '0;
            end
        end else begin
            valid_o <= accept;
            data_o  <= accept ? dec : '0;
            if (accept && adv) begin
                idx <= idx_last ? '0 : idx + IW'(1);
            end
            // A new load wins over everything, including a restart mid-LOAD.
            if (key_load_i) begin
                state <= LOAD;
                key_r <= key;
                len   <= len_clamp;
                cnt   <= '0;
                idx   <= '0;
                busy  <= 1'b1;
            end else if (state == LOAD) begin
                shift[cnt] <= shift_nxt;
                if (load_last) begin
                    state <= RUN;
                    busy  <= 1'b0;
                end else begin
                    cnt <= cnt + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rolling_key_decryption.sv
// Directed-vector bench for rolling_key_decryption (default parameters, A..Z window).
// Each table row is one clock: inputs before the edge, expected outputs after it.
module tb_rolling_key_decryption;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic [31:0] key;
    logic [2:0]  key_len_i;
    logic        key_load_i;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;

    int tests;
    int fails;

    typedef struct {
        logic        ld;
        logic [2:0]  len;
        logic [31:0] key;
        logic        v;
        logic [7:0]  d;
        logic        eb;
        logic        ev;
        logic [7:0]  ed;
    } vec_t;

    vec_t vecs[$];

    rolling_key_decryption dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .key        (key),
        .key_len_i  (key_len_i),
        .key_load_i (key_load_i),
        .busy       (busy),
        .data_o     (data_o),
        .valid_o    (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic ld, input logic [2:0] len,
                                input logic [31:0] k, input logic v,
                                input logic [7:0] d, input logic eb,
                                input logic ev, input logic [7:0] ed);
        vec_t r;
        r.ld  = ld;
        r.len = len;
        r.key = k;
        r.v   = v;
        r.d   = d;
        r.eb  = eb;
        r.ev  = ev;
        r.ed  = ed;
        vecs.push_back(r);
    endfunction

    // Plain cycle: no load, optional data
    function automatic void dat(input logic v, input logic [7:0] d,
                                input logic eb, input logic ev, input logic [7:0] ed);
        add(1'b0, 3'd0, 32'h0, v, d, eb, ev, ed);
    endfunction

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        data_i     = '0;
        valid_i    = 1'b0;
        key        = '0;
        key_len_i  = '0;
        key_load_i = 1'b0;

        // no key: passthrough, then idle output zero
        dat(1, 8'h44, 0, 1, 8'h44);
        dat(0, 8'h00, 0, 0, 8'h00);
        // shifts {1,2,3}: busy three cycles, DDDD -> CBAC
        add(1, 3'd3, 32'h0003_0201, 0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 0, 0, 8'h00);
        dat(1, 8'h44, 0, 1, 8'h43);
        dat(1, 8'h44, 0, 1, 8'h42);
        dat(1, 8'h44, 0, 1, 8'h41);
        dat(1, 8'h44, 0, 1, 8'h43);
        // shift {3}: window wrap A->X, C->Z
        add(1, 3'd1, 32'h0000_0003, 0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 0, 0, 8'h00);
        dat(1, 8'h41, 0, 1, 8'h58);
        dat(1, 8'h43, 0, 1, 8'h5A);
        // shifts {1,2}: space passes and holds idx
        add(1, 3'd2, 32'h0000_0201, 0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 0, 0, 8'h00);
        dat(1, 8'h42, 0, 1, 8'h41);
        dat(1, 8'h20, 0, 1, 8'h20);
        dat(1, 8'h43, 0, 1, 8'h41);
        // len 0 -> 1, 29 mod 26 = 3; valid during busy dropped
        add(1, 3'd0, 32'h0000_001D, 0, 8'h00, 1, 0, 8'h00);
        dat(1, 8'h44, 0, 0, 8'h00);
        dat(1, 8'h44, 0, 1, 8'h41);
        // load + valid in RUN: old key on this char, new key {1} after
        add(1, 3'd1, 32'h0000_0001, 1, 8'h45, 1, 1, 8'h42);
        dat(0, 8'h00, 0, 0, 8'h00);
        dat(1, 8'h42, 0, 1, 8'h41);
        // len 7 clamps to 4: busy four cycles, EEEEE -> DCBAD
        add(1, 3'd7, 32'h0403_0201, 0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 0, 0, 8'h00);
        dat(1, 8'h45, 0, 1, 8'h44);
        dat(1, 8'h45, 0, 1, 8'h43);
        dat(1, 8'h45, 0, 1, 8'h42);
        dat(1, 8'h45, 0, 1, 8'h41);
        dat(1, 8'h45, 0, 1, 8'h44);
        // restart mid-LOAD with shift {5}: one more busy cycle only
        add(1, 3'd3, 32'h0003_0201, 0, 8'h00, 1, 0, 8'h00);
        add(1, 3'd1, 32'h0000_0005, 0, 8'h00, 1, 0, 8'h00);
        dat(0, 8'h00, 0, 0, 8'h00);
        dat(1, 8'h46, 0, 1, 8'h41);

        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset valid_o", 32'(valid_o), 32'h0);
        chk("reset data_o", 32'(data_o), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            key_load_i = vecs[i].ld;
            key_len_i  = vecs[i].len;
            key        = vecs[i].key;
            valid_i    = vecs[i].v;
            data_i     = vecs[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].eb));
            chk($sformatf("row%0d valid_o", i), 32'(valid_o), 32'(vecs[i].ev));
            chk($sformatf("row%0d data_o", i), 32'(data_o), 32'(vecs[i].ed));
        end

        // async reset mid-LOAD while a valid_o pulse is showing
        key_load_i = 1'b1;
        key_len_i  = 3'd3;
        key        = 32'h0003_0201;
        valid_i    = 1'b1;
        data_i     = 8'h46;
        @(posedge clk);
        #1;
        key_load_i = 1'b0;
        valid_i    = 1'b0;
        chk("pre-reset busy", 32'(busy), 32'h1);
        chk("pre-reset valid_o", 32'(valid_o), 32'h1);
        chk("pre-reset data_o", 32'(data_o), 32'h41);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async busy", 32'(busy), 32'h0);
        chk("async valid_o", 32'(valid_o), 32'h0);
        chk("async data_o", 32'(data_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b1;
        data_i  = 8'h44;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        chk("post-reset busy", 32'(busy), 32'h0);
        chk("post-reset valid_o", 32'(valid_o), 32'h1);
        chk("post-reset data_o", 32'(data_o), 32'h44);
        @(posedge clk);
        #1;
        chk("post-reset idle", 32'(data_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
